// File: rtl/esp_psram_64h_pkg.sv
// ESP PSRAM 64H model: shared opcodes, FSM states, ID bytes,
// wait counts and the page-wrapping address increment.
package esp_psram_64h_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FREAD  = 8'h0B;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_QPI_EX = 8'hF5;
  localparam logic [7:0] OP_RST_EN = 8'h66;
  localparam logic [7:0] OP_RST    = 8'h99;
  localparam logic [7:0] OP_RDID   = 8'h9F;

  localparam logic [7:0] MF_ID = 8'h0D;
  localparam logic [7:0] KGD   = 8'h5D;

  localparam logic [4:0] WAIT_FREAD_SPI = 5'd8;
  localparam logic [4:0] WAIT_FREAD_QPI = 5'd4;
  localparam logic [4:0] WAIT_QREAD     = 5'd6;

  // Low 10 bits wrap inside the 1 KiB page.
  function automatic logic [23:0] addr_inc(
    input logic [23:0] a
  );
    return {a[23:10], a[9:0] + 10'd1};
  endfunction

endpackage

// File: rtl/esp_psram_64h_edge_sync.sv
// 2-FF synchronizer with rise/fall pulse outputs on clk_i.
// Ports: clk_i, rst_i, d (async in), rise, fall (1-cycle pulses).
module psram_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [2:0] s;

  always_ff @(posedge clk_i) begin
    if (rst_i) s <= {3{RST_VAL}};
    else       s <= {s[1:0], d};
  end

  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];

endmodule

// File: rtl/esp_psram_64h.sv
// ESP PSRAM 64H serial/quad PSRAM device model (clk_i domain).
// Ports: clk_i, rst_i, sclk, csn (host), sio[3:0] (bidir data).
module esp_psram_64h
  import esp_psram_64h_pkg::*;
#(
  parameter int INST_ID = 0,
  parameter int MEM_AW  = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk,
  input  logic       csn,
  inout  wire  [3:0] sio
);

  localparam logic [1:0] EID = 2'(INST_ID);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  psram_edge_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  psram_edge_sync #(.RST_VAL(1'b1)) u_csn (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (csn),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  logic [7:0]  mem [0:(1<<MEM_AW)-1];

  state_t      state;
  logic        cs_lvl;
  logic        qpi;
  logic        nxt_qpi;
  logic        rst_en;
  logic        is66;
  logic [7:0]  op;
  logic [7:0]  sh;
  logic [7:0]  osh;
  logic [4:0]  cnt;
  logic [23:0] addr;
  logic [1:0]  idc;
  logic [3:0]  dout;
  logic [3:0]  oe;

  logic        wide;
  logic [7:0]  sin;
  logic [23:0] ain;
  logic [4:0]  blast;
  logic [4:0]  alast;
  logic [4:0]  wait_n;
  logic [7:0]  rd_byte;

  for (genvar i = 0; i < 4; i++) begin : g_sio
    assign sio[i] = oe[i] ? dout[i] : 1'bz;
  end

  always_comb begin
    wide = (state == S_CMD) ? qpi :
           (qpi || op == OP_QREAD || op == OP_QWRITE);
    sin   = wide ? {sh[3:0], sio} : {sh[6:0], sio[0]};
    ain   = wide ? {addr[19:0], sio} : {addr[22:0], sio[0]};
    blast = wide ? 5'd1 : 5'd7;
    alast = wide ? 5'd5 : 5'd23;
    wait_n = 5'd0;
    if (op == OP_FREAD)
      wait_n = qpi ? WAIT_FREAD_QPI : WAIT_FREAD_SPI;
    else if (op == OP_QREAD)
      wait_n = WAIT_QREAD;
  end

  always_comb begin
    rd_byte = mem[addr[MEM_AW-1:0]];
    if (op == OP_RDID) begin
      unique case (idc)
        2'd0:    rd_byte = MF_ID;
        2'd1:    rd_byte = KGD;
        2'd2:    rd_byte = {6'b0, EID};
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cs_lvl  <= 1'b1;
      qpi     <= 1'b0;
      nxt_qpi <= 1'b0;
      rst_en  <= 1'b0;
      is66    <= 1'b0;
      op      <= '0;
      sh      <= '0;
      osh     <= '0;
      cnt     <= '0;
      addr    <= '0;
      idc     <= '0;
      dout    <= '0;
      oe      <= '0;
    end else if (cs_fall) begin
      state   <= S_CMD;
      cs_lvl  <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      nxt_qpi <= qpi;
      is66    <= 1'b0;
      idc     <= '0;
    end else if (cs_rise || cs_lvl) begin
      state  <= S_IDLE;
      cs_lvl <= 1'b1;
      oe     <= '0;
      cnt    <= '0;
      sh     <= '0;
      // Mode and reset-enable changes land at end of transaction.
      if (cs_rise) begin
        qpi    <= nxt_qpi;
        rst_en <= is66;
      end
    end else begin
      unique case (state)
        S_CMD: if (sclk_rise) begin
          sh  <= sin;
          cnt <= cnt + 5'd1;
          if (cnt == blast) begin
            cnt   <= '0;
            op    <= sin;
            state <= S_IGNORE;
            unique case (1'b1)
              sin == OP_READ,
              sin == OP_RDID:
                state <= qpi ? S_IGNORE : S_ADDR;
              sin == OP_FREAD,
              sin == OP_QREAD,
              sin == OP_WRITE,
              sin == OP_QWRITE:
                state <= S_ADDR;
              sin == OP_QPI_EN: nxt_qpi <= 1'b1;
              sin == OP_QPI_EX: nxt_qpi <= 1'b0;
              sin == OP_RST_EN: is66 <= 1'b1;
              sin == OP_RST:
                if (rst_en) nxt_qpi <= 1'b0;
              default: ;
            endcase
          end
        end
        S_ADDR: if (sclk_rise) begin
          addr <= ain;
          cnt  <= cnt + 5'd1;
          if (cnt == alast) begin
            cnt <= '0;
            if (op == OP_WRITE || op == OP_QWRITE)
              state <= S_WDATA;
            else if (wait_n == 5'd0)
              state <= S_RDATA;
            else
              state <= S_WAIT;
          end
        end
        S_WAIT: if (sclk_rise) begin
          cnt <= cnt + 5'd1;
          if (cnt == wait_n - 5'd1) begin
            cnt   <= '0;
            state <= S_RDATA;
          end
        end
        S_RDATA: if (sclk_fall) begin
          oe  <= wide ? 4'b1111 : 4'b0010;
          cnt <= (cnt == blast) ? 5'd0 : cnt + 5'd1;
          if (cnt == 5'd0) begin
            dout <= wide ? rd_byte[7:4]
                         : {2'b0, rd_byte[7], 1'b0};
            osh  <= wide ? {rd_byte[3:0], 4'b0}
                         : {rd_byte[6:0], 1'b0};
            addr <= addr_inc(addr);
            if (idc != 2'd3) idc <= idc + 2'd1;
          end else begin
            dout <= wide ? osh[7:4] : {2'b0, osh[7], 1'b0};
            osh  <= wide ? {osh[3:0], 4'b0} : {osh[6:0], 1'b0};
          end
        end
        S_WDATA: if (sclk_rise) begin
          sh  <= sin;
          cnt <= cnt + 5'd1;
          if (cnt == blast) begin
            cnt  <= '0;
            mem[addr[MEM_AW-1:0]] <= sin;
            addr <= addr_inc(addr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_esp_psram_64h.sv
// Directed bench for esp_psram_64h acting as a PSRAM host.
// Drives sclk/csn/sio, checks read-back with immediate asserts.
module tb_esp_psram_64h;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       sclk;
  logic       csn;
  logic [3:0] host_do;
  logic [3:0] host_oe;
  wire  [3:0] sio;

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 4; i++) begin : g_host
    assign sio[i] = host_oe[i] ? host_do[i] : 1'bz;
  end

  esp_psram_64h #(.INST_ID(2), .MEM_AW(12)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sclk  (sclk),
    .csn   (csn),
    .sio   (sio)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h",
             tag, obs, exp);
    end
  endtask

  // One sclk period: present data while low, sample before rise.
  task automatic clk1(input  logic [3:0] d,
                      input  logic [3:0] en,
                      output logic [3:0] q);
    host_do = d;
    host_oe = en;
    #40;
    q = sio;
    sclk = 1'b1;
    #40;
    sclk = 1'b0;
  endtask

  task automatic cs_on();
    csn = 1'b0;
    #80;
  endtask

  task automatic cs_off();
    #40;
    csn = 1'b0;
    csn = 1'b1;
    host_oe = 4'b0;
    #120;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit wide);
    logic [3:0] q;
    if (wide) begin
      clk1(b[7:4], 4'hF, q);
      clk1(b[3:0], 4'hF, q);
    end else begin
      for (int i = 7; i >= 0; i--)
        clk1({3'b0, b[i]}, 4'b0001, q);
    end
  endtask

  task automatic send_addr(input logic [23:0] a,
                           input bit wide);
    logic [3:0] q;
    if (wide) begin
      for (int i = 5; i >= 0; i--)
        clk1(a[i*4 +: 4], 4'hF, q);
    end else begin
      for (int i = 23; i >= 0; i--)
        clk1({3'b0, a[i]}, 4'b0001, q);
    end
  endtask

  task automatic dummy(input int n);
    logic [3:0] q;
    for (int i = 0; i < n; i++)
      clk1(4'h0, 4'h0, q);
  endtask

  task automatic recv_byte(input bit wide,
                           output logic [7:0] b);
    logic [3:0] q;
    b = 8'h00;
    if (wide) begin
      clk1(4'h0, 4'h0, q);
      b[7:4] = q;
      clk1(4'h0, 4'h0, q);
      b[3:0] = q;
    end else begin
      for (int i = 0; i < 8; i++) begin
        clk1(4'h0, 4'h0, q);
        b = {b[6:0], q[1]};
      end
    end
  endtask

  task automatic cmd_only(input logic [7:0] op,
                          input bit wide);
    cs_on();
    send_byte(op, wide);
    cs_off();
  endtask

  task automatic spi_read1(input logic [23:0] a,
                           output logic [7:0] b);
    cs_on();
    send_byte(8'h03, 1'b0);
    send_addr(a, 1'b0);
    recv_byte(1'b0, b);
    cs_off();
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;
    logic [3:0] q;
    rst_i   = 1'b1;
    sclk    = 1'b0;
    csn     = 1'b1;
    host_do = 4'h0;
    host_oe = 4'h0;
    #100;
    rst_i = 1'b0;
    #100;

    // SPI write then SPI read
    cs_on();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000010, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    cs_off();
    cs_on();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000010, 1'b0);
    recv_byte(1'b0, b0);
    recv_byte(1'b0, b1);
    cs_off();
    check("spi_rd0", b0, 8'hA5);
    check("spi_rd1", b1, 8'h3C);

    // Quad write across page end, quad read back
    cs_on();
    send_byte(8'h38, 1'b0);
    send_addr(24'h0003FF, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cs_off();
    cs_on();
    send_byte(8'hEB, 1'b0);
    send_addr(24'h0003FF, 1'b1);
    dummy(6);
    recv_byte(1'b1, b0);
    recv_byte(1'b1, b1);
    cs_off();
    check("qrd0", b0, 8'h11);
    check("qrd1_wrap", b1, 8'h22);
    spi_read1(24'h000000, b0);
    check("wrap_addr0", b0, 8'h22);

    // QPI mode fast read, then exit QPI
    cmd_only(8'h35, 1'b0);
    cs_on();
    send_byte(8'h0B, 1'b1);
    send_addr(24'h000010, 1'b1);
    dummy(4);
    recv_byte(1'b1, b0);
    recv_byte(1'b1, b1);
    cs_off();
    check("qpi_frd0", b0, 8'hA5);
    check("qpi_frd1", b1, 8'h3C);
    cmd_only(8'hF5, 1'b1);
    spi_read1(24'h000010, b0);
    check("spi_after_f5", b0, 8'hA5);

    // Read ID
    cs_on();
    send_byte(8'h9F, 1'b0);
    send_addr(24'h000000, 1'b0);
    recv_byte(1'b0, b0);
    recv_byte(1'b0, b1);
    recv_byte(1'b0, b2);
    recv_byte(1'b0, b3);
    cs_off();
    check("id_mf", b0, 8'h0D);
    check("id_kgd", b1, 8'h5D);
    check("id_eid", b2, 8'h02);
    check("id_pad", b3, 8'h00);

    // Partial byte discarded at csn rise
    cs_on();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000021, 1'b0);
    send_byte(8'hE1, 1'b0);
    cs_off();
    cs_on();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000020, 1'b0);
    send_byte(8'h77, 1'b0);
    for (int i = 0; i < 4; i++)
      clk1(4'h1, 4'b0001, q);
    cs_off();
    cs_on();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000020, 1'b0);
    recv_byte(1'b0, b0);
    recv_byte(1'b0, b1);
    cs_off();
    check("partial_20", b0, 8'h77);
    check("partial_21", b1, 8'hE1);

    // 0x99 without 0x66 keeps QPI
    cmd_only(8'h35, 1'b0);
    cmd_only(8'h99, 1'b1);
    cs_on();
    send_byte(8'h0B, 1'b1);
    send_addr(24'h000020, 1'b1);
    dummy(4);
    recv_byte(1'b1, b0);
    cs_off();
    check("rst_no_en", b0, 8'h77);

    // 0x66 then 0x99 returns to SPI
    cmd_only(8'h66, 1'b1);
    cmd_only(8'h99, 1'b1);
    spi_read1(24'h000020, b0);
    check("rst_en_spi", b0, 8'h77);

    // rst_i mid QPI write: aborts, keeps memory, mode SPI
    cmd_only(8'h35, 1'b0);
    cs_on();
    send_byte(8'h02, 1'b1);
    send_addr(24'h000030, 1'b1);
    send_byte(8'h5A, 1'b1);
    cs_off();
    cs_on();
    send_byte(8'h02, 1'b1);
    send_addr(24'h000030, 1'b1);
    clk1(4'hC, 4'hF, q);
    #40;
    rst_i = 1'b1;
    #60;
    rst_i = 1'b0;
    #60;
    csn = 1'b1;
    host_oe = 4'h0;
    #120;
    spi_read1(24'h000030, b0);
    check("rst_mid_wr", b0, 8'h5A);
    spi_read1(24'h000010, b0);
    check("rst_keep_mem", b0, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esp_psram_64h.md
ESP_PSRAM_64H -- requirements
Module: esp_psram_64h

Interface
REQ-001 Parameter: INST_ID, default 0, instance number (0-3) returned as the low 2 bits of the read-ID EID byte.
REQ-002 Parameter: MEM_AW, default 12, byte-address width of the internal array (2^MEM_AW bytes); higher address bits are ignored.
REQ-003 Port: clk_i  input  1  single system clock; must run at least 4x the sclk frequency.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port: sclk  input  1  serial clock from the host PSRAM controller.
REQ-006 Port: csn  input  1  chip select, active-low.
REQ-007 Port: sio  inout  4  data bus {SIO3,SIO2,SIO1,SIO0}; high-Z whenever the device is not driving.

Function
REQ-008 sclk and csn shall pass through 2-FF synchronizers on clk_i, with rise/fall detection; all logic is clk_i-synchronous.
REQ-009 Input bits shall be sampled on detected sclk rise; output bits shall update on detected sclk fall, within 3 clk_i cycles of the real edge.
REQ-010 Mode register: SPI (1-bit in on SIO0, out on SIO1) or QPI (4-bit, nibble MSB first); reset value SPI.
REQ-011 States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE; csn fall -> CMD; csn high in any state -> IDLE next clk_i cycle, sio released.
REQ-012 CMD: 8 bits (SPI) or 2 nibbles (QPI), MSB first; unknown opcode -> IGNORE until csn rises.
REQ-013 Supported opcodes: 0x03 read (no wait, SPI only), 0x0B fast read (8 wait clocks in SPI, 4 in QPI), 0xEB quad read (6 wait clocks, 4-bit address and data), 0x02 write, 0x38 quad write (4-bit address and data, no wait), 0x35 enter QPI, 0xF5 exit QPI, 0x66 reset-enable, 0x99 reset, 0x9F read ID (SPI only).
REQ-014 Address: 24 bits MSB first; 24 clocks in 1-bit mode, 6 clocks in 4-bit mode (0xEB/0x38 and all QPI commands).
REQ-015 Read: the first data bit/nibble of mem[addr] shall appear on the sclk fall that ends the last wait/address clock; bytes stream MSB first, address +1 per byte.
REQ-016 Address increment shall wrap within the 1 KiB page (addr[9:0] wraps, upper bits held), then be taken modulo 2^MEM_AW.
REQ-017 Write: each completed byte is committed to mem[addr] immediately; address increment as REQ-016; a partial byte at csn rise is discarded.
REQ-018 sio output enable: SPI reads drive SIO1 only; quad/QPI reads drive all 4 bits; output is enabled only in RDATA.
REQ-019 0x35 / 0xF5 take effect at csn rise; 0x99 takes effect only when the immediately preceding transaction was 0x66, and returns mode to SPI.
REQ-020 0x9F: 24 address clocks (ignored), then bytes 0x0D (MF ID), 0x5D (KGD), then EID byte {6'b0, INST_ID[1:0]}, then 0x00 repeated.
REQ-021 Opcodes 0x03 and 0x9F issued in QPI mode shall go to IGNORE.

Reset
REQ-022 rst_i shall set state IDLE, mode SPI, reset-enable flag clear, all sio output enables 0 (high-Z), and shift/count registers 0.
REQ-023 rst_i shall not clear the memory array; reset asserted mid-transaction aborts it as if csn had risen, without committing a partial byte.

Structure
REQ-024 Package esp_psram_64h_pkg shall hold the opcode constants, the state enum, MF ID/KGD constants and the wait-cycle counts.
REQ-025 One sub-module, psram_edge_sync (2-FF synchronizer plus edge detector), is instantiated for sclk and csn; everything else lives in a single module.

Verification
REQ-026 SPI 0x02 at addr 0x000010 with data A5,3C, then SPI 0x03 at 0x000010 -> SIO1 returns A5,3C.
REQ-027 SPI 0x38 quad write at 0x0003FF with 11,22, then 0xEB with 6 waits at 0x0003FF -> read 11,22; 0x22 is stored at 0x000000 (page wrap).
REQ-028 0x35, then QPI 0x0B at 0x000010 with 4 waits -> nibbles A,5,3,C on sio[3:0]; 0xF5 -> next SPI 0x03 works again.
REQ-029 0x9F on an instance with INST_ID=2 -> bytes 0D,5D,02.
REQ-030 csn raised after 4 bits of the second byte of a write to 0x20 (first byte 77) -> 0x20=77, 0x21 unchanged; 0x99 without a preceding 0x66 -> mode unchanged.
